// File: rtl/memoria_fila.sv
`default_nettype none
// ============================================================================
// Module      : memoria_fila
// Description : Synchronous single-clock FIFO on an inferred dual-port RAM,
//               with occupancy count, status flags, flush and sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================
module memoria_fila #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 6,
    parameter int ALMOST_FULL = 56
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  limpa,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  EscFila,
    input  logic                  LerFila,
    output logic [DATA_WIDTH-1:0] saida,
    output logic                  valido,
    output logic                  vazia,
    output logic                  cheia,
    output logic                  quase_cheia,
    output logic [ADDR_WIDTH:0]   contagem,
    output logic                  erro_overflow,
    output logic                  erro_underflow
);

    localparam int                c_DEPTH_INT = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH   = (ADDR_WIDTH+1)'(c_DEPTH_INT);
    localparam logic [ADDR_WIDTH:0] c_ALMOST  = (ADDR_WIDTH+1)'(ALMOST_FULL);

    logic [DATA_WIDTH-1:0] r_ram [0:c_DEPTH_INT-1];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_saida;
    logic                  r_valido;
    logic                  r_ovf;
    logic                  r_unf;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    // A pop frees a slot in the same edge, so a full FIFO may still accept a push.
    assign w_pop_ok  = LerFila && !w_empty;
    assign w_push_ok = EscFila && (!w_full || w_pop_ok);

    // Storage has no reset; discarded contents are unreachable through the pointers.
    always_ff @(posedge clock) begin
        if (!reset && !limpa && w_push_ok) begin
            r_ram[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_saida  <= '0;
            r_valido <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (limpa) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valido <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end else if (EscFila) begin
                r_ovf <= 1'b1;
            end

            if (w_pop_ok) begin
                r_saida  <= r_ram[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_valido <= 1'b1;
            end else begin
                r_valido <= 1'b0;
                if (LerFila) begin
                    r_unf <= 1'b1;
                end
            end

            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign saida          = r_saida;
    assign valido         = r_valido;
    assign vazia          = w_empty;
    assign cheia          = w_full;
    assign quase_cheia    = (r_count >= c_ALMOST);
    assign contagem       = r_count;
    assign erro_overflow  = r_ovf;
    assign erro_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_memoria_fila.sv
`default_nettype none
// ============================================================================
// Module      : tb_memoria_fila
// Description : Self-checking bench for memoria_fila against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memoria_fila;

    localparam int c_DW    = 8;
    localparam int c_AW    = 6;
    localparam int c_DEPTH = 64;
    localparam int c_AF    = 56;

    logic              clock;
    logic              reset;
    logic              limpa;
    logic [c_DW-1:0]   data;
    logic              EscFila;
    logic              LerFila;
    logic [c_DW-1:0]   saida;
    logic              valido;
    logic              vazia;
    logic              cheia;
    logic              quase_cheia;
    logic [c_AW:0]     contagem;
    logic              erro_overflow;
    logic              erro_underflow;

    memoria_fila #(
        .DATA_WIDTH  (c_DW),
        .ADDR_WIDTH  (c_AW),
        .ALMOST_FULL (c_AF)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .limpa          (limpa),
        .data           (data),
        .EscFila        (EscFila),
        .LerFila        (LerFila),
        .saida          (saida),
        .valido         (valido),
        .vazia          (vazia),
        .cheia          (cheia),
        .quase_cheia    (quase_cheia),
        .contagem       (contagem),
        .erro_overflow  (erro_overflow),
        .erro_underflow (erro_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents as a queue, plus the visible registered outputs.
    logic [c_DW-1:0] m_q [$];
    logic [c_DW-1:0] m_saida = '0;
    logic            m_valido = 1'b0;
    logic            m_ovf = 1'b0;
    logic            m_unf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic fl, input logic push,
                                input logic pop, input logic [c_DW-1:0] d);
        bit was_empty, was_full, pop_ok, push_ok;
        if (rst) begin
            m_q.delete();
            m_saida  = '0;
            m_valido = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else if (fl) begin
            m_q.delete();
            m_valido = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            was_empty = (m_q.size() == 0);
            was_full  = (m_q.size() == c_DEPTH);
            pop_ok    = pop && !was_empty;
            push_ok   = push && (!was_full || pop_ok);
            if (pop_ok) begin
                m_saida  = m_q.pop_front();
                m_valido = 1'b1;
            end else begin
                m_valido = 1'b0;
                if (pop) m_unf = 1'b1;
            end
            if (push_ok) m_q.push_back(d);
            else if (push) m_ovf = 1'b1;
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = m_q.size();
        check("saida",          32'(saida),          32'(m_saida));
        check("valido",         32'(valido),         32'(m_valido));
        check("contagem",       32'(contagem),       32'(sz));
        check("vazia",          32'(vazia),          32'(sz == 0));
        check("cheia",          32'(cheia),          32'(sz == c_DEPTH));
        check("quase_cheia",    32'(quase_cheia),    32'(sz >= c_AF));
        check("erro_overflow",  32'(erro_overflow),  32'(m_ovf));
        check("erro_underflow", 32'(erro_underflow), 32'(m_unf));
    endtask

    // One clock: apply inputs, take the edge, update the model, compare after the edge.
    task automatic step(input logic rst, input logic fl, input logic push,
                        input logic pop, input logic [c_DW-1:0] d);
        reset   = rst;
        limpa   = fl;
        EscFila = push;
        LerFila = pop;
        data    = d;
        @(posedge clock);
        model_update(rst, fl, push, pop, d);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; limpa = 1'b0; EscFila = 1'b0; LerFila = 1'b0; data = '0;
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);

        // Basic three-word push then pop
        step(0, 0, 1, 0, 8'h11);
        step(0, 0, 1, 0, 8'h22);
        step(0, 0, 1, 0, 8'h33);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h00);
        check("basic_last_saida", 32'(saida), 32'h33);
        step(0, 0, 0, 0, 8'h00);

        // Fill to full, overflow with 0xAA, then drain
        for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 8'(i));
        check("full_flag", 32'(cheia), 32'd1);
        step(0, 0, 1, 0, 8'hAA);
        check("ovf_set", 32'(erro_overflow), 32'd1);
        for (int i = 0; i < 64; i++) begin
            step(0, 0, 0, 1, 8'h00);
            check("drain_order", 32'(saida), 32'(i));
        end

        // Full with simultaneous push/pop
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 8'(i));
        step(0, 0, 1, 1, 8'h55);
        check("full_rw_count", 32'(contagem), 32'd64);
        for (int i = 0; i < 63; i++) step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        check("full_rw_last", 32'(saida), 32'h55);

        // Empty with simultaneous push/pop
        step(0, 0, 1, 1, 8'h7E);
        check("empty_rw_unf", 32'(erro_underflow), 32'd1);
        step(0, 0, 0, 1, 8'h00);
        check("empty_rw_data", 32'(saida), 32'h7E);

        // Wrap test at occupancy 10
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 8'(i));
        for (int i = 10; i < 200; i++) step(0, 0, 1, 1, 8'(i));
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'h00);
        check("wrap_last", 32'(saida), 32'd199);

        // Flush with 5 stored and overflow set
        for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 8'(i + 8'h40));
        step(0, 0, 1, 0, 8'hEE);
        for (int i = 0; i < 59; i++) step(0, 0, 0, 1, 8'h00);
        check("pre_flush_count", 32'(contagem), 32'd5);
        step(0, 1, 1, 0, 8'hCC);
        step(0, 0, 1, 0, 8'h99);
        step(0, 0, 0, 1, 8'h00);
        check("post_flush_data", 32'(saida), 32'h99);

        // Randomized traffic with phases of varying push/pop bias
        for (int ph = 0; ph < 10; ph++) begin
            int pw;
            pw = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
            for (int i = 0; i < 300; i++) begin
                logic r_, f_, p_, q_;
                r_ = ($urandom_range(0, 399) == 0);
                f_ = ($urandom_range(0, 127) == 0);
                p_ = ($urandom_range(0, 99) < pw);
                q_ = ($urandom_range(0, 99) < (100 - pw));
                step(r_, f_, p_, q_, 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
